// File: rtl/sysbus_mem_responder_if.sv
// sysbus_mem_responder_if: system bus request/response bundle between initiator and memory responder
interface sysbus_mem_responder_if #(
    parameter int DW = 64,
    parameter int TW = 13
);
    logic          reqcyc;
    logic          reqack;
    logic [DW-1:0] req;
    logic [TW-1:0] reqtag;
    logic          respcyc;
    logic          respack;
    logic [DW-1:0] resp;
    logic [TW-1:0] resptag;
    modport master (output reqcyc, req, reqtag, respack, input reqack, respcyc, resp, resptag);
    modport slave  (input reqcyc, req, reqtag, respack, output reqack, respcyc, resp, resptag);
endinterface

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: 64-byte line store behind the system bus; `MEMRESP_CWF_EN selects critical-word-first reads
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_LINES      = 64,
    parameter int READ_LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sysbus_mem_responder_if.slave bus
);
    localparam int LW = $clog2(MEM_LINES);
    localparam int CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic SYSBUS_WRITE = 1'b0;

    typedef enum logic [2:0] {IDLE, ACK, WRDATA, WACK, RDWAIT, RESP} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               ptr_q, ptr_d;
    logic [2:0]               start_q, start_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [LW-1:0]            line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
    logic                     reqack_q, reqack_d;
    logic                     respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0] resptag_q, resptag_d;
    logic [7:0][BUS_DATA_WIDTH-1:0] wbuf_q;
    logic [7:0][BUS_DATA_WIDTH-1:0] mem [MEM_LINES];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: if (bus.reqcyc) begin
                state_d = ACK;
                line_d  = bus.req[6 +: LW];
                tag_d   = bus.reqtag;
`ifdef MEMRESP_CWF_EN
                start_d = (bus.reqtag[BUS_TAG_WIDTH-1] == SYSBUS_WRITE) ? 3'd0 : bus.req[5:3];
`else
                start_d = 3'd0;
`endif
                ptr_d   = start_d;
            end
            ACK: begin
                if (tag_q[BUS_TAG_WIDTH-1] == SYSBUS_WRITE) state_d = WRDATA;
                else if (READ_LATENCY == 0) state_d = RESP;
                else begin
                    cnt_d   = CW'(READ_LATENCY);
                    state_d = RDWAIT;
                end
            end
            WRDATA: state_d = bus.reqcyc ? WACK : WRDATA;
            WACK: begin
                state_d = (ptr_q == 3'd7) ? IDLE : WRDATA;
                ptr_d   = (ptr_q == 3'd7) ? ptr_q : ptr_q + 3'd1;
            end
            RDWAIT: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q <= CW'(1)) ? RESP : RDWAIT;
            end
            RESP: if (bus.respack) begin
                // the beat before the starting word is the last one, so CWF reads wrap through word 0
                state_d = (ptr_q == start_q - 3'd1) ? IDLE : RESP;
                ptr_d   = (ptr_q == start_q - 3'd1) ? ptr_q : ptr_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
        reqack_d  = (state_q == IDLE || state_q == WRDATA) && bus.reqcyc;
        respcyc_d = (state_d == RESP);
        resp_d    = respcyc_d ? mem[line_q][ptr_d] : '0;
        resptag_d = respcyc_d ? tag_q : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            start_q   <= '0;
            cnt_q     <= '0;
            line_q    <= '0;
            tag_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    // store and write buffer survive reset; a partial line never reaches the store
    always_ff @(posedge clk) begin
        if (state_q == WRDATA && bus.reqcyc) wbuf_q[ptr_q] <= bus.req;
        if (state_q == WACK && ptr_q == 3'd7) mem[line_q] <= wbuf_q;
    end

    assign bus.reqack  = reqack_q;
    assign bus.respcyc = respcyc_q;
    assign bus.resp    = resp_q;
    assign bus.resptag = resptag_q;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: directed scoreboard bench for sysbus_mem_responder (latency 4 and latency 0 instances)
module tb_sysbus_mem_responder;
    localparam logic [12:0] WTAG = 13'h00AB;
    localparam logic [12:0] RTAG = 13'h1123;

    logic clk = 1'b0;
    logic reset_n;
    int total = 0;
    int bad = 0;
    logic [63:0] sb[$];
    logic [63:0] mdl [64][8];

    sysbus_mem_responder_if #(.DW(64), .TW(13)) bus ();
    sysbus_mem_responder_if #(.DW(64), .TW(13)) bus0 ();

    sysbus_mem_responder #(.READ_LATENCY(4)) dut  (.clk(clk), .reset(reset_n), .bus(bus));
    sysbus_mem_responder #(.READ_LATENCY(0)) dut0 (.clk(clk), .reset(reset_n), .bus(bus0));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.reqack && n < 20);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] base);
        int n;
        int acks;
        acks = 0;
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = WTAG;
        wait_ack(n);
        chk("wr_req_ack_lat", 64'(n), 64'd1);
        for (int i = 0; i < 8; i++) begin
            bus.req = base * 64'(i + 1);
            wait_ack(n);
            if (n < 20) acks++;
            mdl[addr[11:6]][i] = base * 64'(i + 1);
        end
        bus.reqcyc = 1'b0;
        chk("wr_wack_count", 64'(acks), 64'd8);
        tick();
        chk("wr_ack_drop", 64'(bus.reqack), 64'd0);
    endtask

    task automatic do_read(input logic [63:0] addr, input int hold_beat, input int hold_n);
        int n;
        logic [2:0] w;
        logic [63:0] e;
`ifdef MEMRESP_CWF_EN
        w = addr[5:3];
`else
        w = 3'd0;
`endif
        for (int i = 0; i < 8; i++) begin
            sb.push_back(mdl[addr[11:6]][w]);
            w++;
        end
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = RTAG;
        wait_ack(n);
        bus.reqcyc = 1'b0;
        chk("rd_req_ack_lat", 64'(n), 64'd1);
        while (!bus.respcyc && n < 40) begin
            tick();
            n++;
        end
        chk("rd_first_beat_lat", 64'(n), 64'd6);
        for (int b = 0; b < 8; b++) begin
            chk("rd_respcyc", 64'(bus.respcyc), 64'd1);
            for (int h = 0; b == hold_beat && h < hold_n; h++) begin
                bus.respack = 1'b0;
                tick();
                chk("rd_hold_data", bus.resp, sb[0]);
                chk("rd_hold_valid", 64'(bus.respcyc), 64'd1);
            end
            bus.respack = 1'b1;
            e = sb.pop_front();
            chk("rd_data", bus.resp, e);
            chk("rd_tag", 64'(bus.resptag), 64'(RTAG));
            tick();
        end
        bus.respack = 1'b0;
        chk("rd_end_idle", 64'(bus.respcyc), 64'd0);
    endtask

    initial begin
        int n;
        int k;
        reset_n      = 1'b0;
        bus.reqcyc   = 1'b0;
        bus.req      = '0;
        bus.reqtag   = '0;
        bus.respack  = 1'b0;
        bus0.reqcyc  = 1'b0;
        bus0.req     = '0;
        bus0.reqtag  = '0;
        bus0.respack = 1'b0;
        repeat (3) tick();
        chk("rst_reqack", 64'(bus.reqack), 64'd0);
        chk("rst_respcyc", 64'(bus.respcyc), 64'd0);
        chk("rst_resp", bus.resp, 64'd0);
        chk("rst_resptag", 64'(bus.resptag), 64'd0);
        reset_n = 1'b1;
        tick();

        do_write(64'h40, 64'h11);
        do_read(64'h40, 2, 5);
        do_read(64'h58, -1, 0);

        sb.delete();
        bus.reqcyc = 1'b1;
        bus.req    = 64'h40;
        bus.reqtag = RTAG;
        wait_ack(n);
        bus.reqcyc = 1'b0;
        while (!bus.respcyc && n < 40) begin
            tick();
            n++;
        end
        bus.respack = 1'b1;
        repeat (3) tick();
        bus.respack = 1'b0;
        chk("mid_resp_beat3", bus.resp, mdl[1][3]);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_respcyc", 64'(bus.respcyc), 64'd0);
        chk("mid_rst_resp", bus.resp, 64'd0);
        chk("mid_rst_resptag", 64'(bus.resptag), 64'd0);
        chk("mid_rst_reqack", 64'(bus.reqack), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        do_read(64'h40, -1, 0);

        do_write(64'h40 + 64'(64 * 64), 64'hA0);
        do_read(64'h40, -1, 0);

        bus0.reqcyc = 1'b1;
        bus0.req    = 64'h80;
        bus0.reqtag = RTAG;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus0.reqack && n < 20);
        bus0.reqcyc = 1'b0;
        chk("l0_ack_lat", 64'(n), 64'd1);
        while (!bus0.respcyc && n < 40) begin
            tick();
            n++;
        end
        chk("l0_first_beat_lat", 64'(n), 64'd2);
        chk("l0_tag", 64'(bus0.resptag), 64'(RTAG));
        bus0.respack = 1'b1;
        k = 0;
        while (bus0.respcyc && k < 20) begin
            tick();
            k++;
        end
        bus0.respack = 1'b0;
        chk("l0_beats", 64'(k), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
